// File: rtl/sprite_cmd_queue.sv
// Sprite command queue: CPU register file and command FIFO feeding a paced,
// registered active-low write strobe into the graphics card.
module sprite_cmd_queue #(
    parameter int DEPTH  = 8,
    parameter int WR_LOW = 2
) (
    input  logic        ppu_fclk,
    input  logic        ppu_rst,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic [1:0]  cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        ppu_wrn,
    output logic [9:0]  ppu_sprite_x,
    output logic [8:0]  ppu_sprite_y,
    output logic [8:0]  ppu_sprite_id
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STB_W = (WR_LOW > 1) ? $clog2(WR_LOW) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

    state_t             state_q, state_d;
    logic [STB_W-1:0]   stb_cnt;
    logic [9:0]         x_stage;
    logic [8:0]         y_stage;
    logic [8:0]         last_id;
    logic               overflow;
    logic [27:0]        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;

    logic push_req, push_ok, pop, flush, overflow_evt, status_rd;
    logic [15:0] status;

    assign push_req     = cpu_wr && (cpu_addr == 2'd2);
    assign push_ok      = push_req && (count < CNT_W'(DEPTH));
    assign overflow_evt = push_req && !push_ok;
    assign flush        = cpu_wr && (cpu_addr == 2'd3) && cpu_wdata[0];
    assign pop          = (state_q == IDLE) && (count != '0);
    assign status_rd    = cpu_rd && (cpu_addr == 2'd3);

    assign status = {8'h00, 4'(count), (state_q != IDLE), overflow,
                     (count == CNT_W'(DEPTH)), (count == '0)};

    // NOTE: every clocked block uses non-blocking assignments so all flops
    // sample pre-edge values, which is what makes read-before-write work.
    always_ff @(posedge ppu_fclk or negedge ppu_rst) begin
        if (!ppu_rst) begin
            x_stage  <= '0;
            y_stage  <= '0;
            last_id  <= '0;
            overflow <= 1'b0;
        end else begin
            if (cpu_wr && cpu_addr == 2'd0) x_stage <= cpu_wdata[9:0];
            if (cpu_wr && cpu_addr == 2'd1) y_stage <= cpu_wdata[8:0];
            if (push_req)                   last_id <= cpu_wdata[8:0];
            // A coincident overflow wins over the read-to-clear.
            if (overflow_evt)   overflow <= 1'b1;
            else if (status_rd) overflow <= 1'b0;
        end
    end

    always_ff @(posedge ppu_fclk or negedge ppu_rst) begin
        if (!ppu_rst) begin
            cpu_rdata <= '0;
        end else if (cpu_rd) begin
            case (cpu_addr)
                2'd0:    cpu_rdata <= {6'b0, x_stage};
                2'd1:    cpu_rdata <= {7'b0, y_stage};
                2'd2:    cpu_rdata <= {7'b0, last_id};
                default: cpu_rdata <= status;
            endcase
        end
    end

    // NOTE: the storage array has no reset; entries are only ever read after
    // being written, so resetting it would add logic for no behaviour.
    always_ff @(posedge ppu_fclk) begin
        if (push_ok) mem[wr_ptr] <= {x_stage, y_stage, cpu_wdata[8:0]};
    end

    always_ff @(posedge ppu_fclk or negedge ppu_rst) begin
        if (!ppu_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop) state_d = SETUP;
            SETUP:   state_d = STROBE;
            STROBE:  if (stb_cnt == STB_W'(WR_LOW - 1)) state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ppu_wrn is registered from the next state, so it is a clean flop output.
    always_ff @(posedge ppu_fclk or negedge ppu_rst) begin
        if (!ppu_rst) begin
            state_q       <= IDLE;
            stb_cnt       <= '0;
            ppu_wrn       <= 1'b1;
            ppu_sprite_x  <= '0;
            ppu_sprite_y  <= '0;
            ppu_sprite_id <= '0;
        end else begin
            state_q <= state_d;
            stb_cnt <= (state_q == STROBE) ? stb_cnt + 1'b1 : '0;
            ppu_wrn <= (state_d != STROBE);
            if (pop) {ppu_sprite_x, ppu_sprite_y, ppu_sprite_id} <= mem[rd_ptr];
        end
    end

endmodule

// File: doc/sprite_cmd_queue.md
# sprite_cmd_queue

CPU-side front end for the graphics card. It takes memory-mapped sprite commands from the CPU bus, stages X/Y/ID fields, and buffers complete commands in a FIFO. It then replays each command as a paced, glitch-free active-low write strobe on the `ppu_wrn` / `ppu_sprite_*` inputs of the graphics card. This decouples CPU store timing from the frame-buffer write path.

## Interface

**Parameters**
- `DEPTH`, 8 — FIFO entries; power of 2, 2..8.
- `WR_LOW`, 2 — cycles `ppu_wrn` is held low per command; ≥1.

**Ports**
- `ppu_fclk`  in  1  — sole clock; all logic rising-edge.
- `ppu_rst`  in  1  — asynchronous, active-low reset.
- `cpu_wr`  in  1  — one-cycle write strobe, active high.
- `cpu_rd`  in  1  — one-cycle read strobe, active high.
- `cpu_addr`  in  2  — register select.
- `cpu_wdata`  in  16  — write data.
- `cpu_rdata`  out  16  — registered read data.
- `ppu_wrn`  out  1  — active-low sprite write strobe to the graphics card.
- `ppu_sprite_x`  out  10  — sprite X.
- `ppu_sprite_y`  out  9  — sprite Y.
- `ppu_sprite_id`  out  9  — sprite ID.

## Operation

**Register map, write**
- addr0: X stage ← `wdata[9:0]`.
- addr1: Y stage ← `wdata[8:0]`.
- addr2: push `{Xstage, Ystage, wdata[8:0]}`; last_id ← `wdata[8:0]`.
- addr3: `wdata[0]`=1 flushes the FIFO.
- Upper bits of each field are ignored.

**Register map, read** (data in `cpu_rdata` on the cycle after `cpu_rd`)
- addr0: X stage.
- addr1: Y stage.
- addr2: last_id.
- addr3: status — [0] empty, [1] full, [2] overflow (sticky), [3] busy (FSM not IDLE), [7:4] count, [15:8] 0.
- Reading addr3 clears overflow. If an overflow event occurs in the same cycle, overflow stays 1.
- `cpu_rdata` holds its value when `cpu_rd`=0.

**FIFO**
- 28-bit entries, `DEPTH` deep; count ranges 0..`DEPTH`.
- A push is accepted only if count<`DEPTH` at the start of the cycle; a pop in the same cycle does not free space. A rejected push is dropped and sets overflow.
- Simultaneous accepted push and pop: count unchanged.
- Flush sets count 0. It does not abort a command already loaded into the output registers. A flush coinciding with a pop still ends with count 0.
- Pointers wrap modulo `DEPTH`.

**Output FSM**
- IDLE (`wrn`=1): if count>0, pop the head into `ppu_sprite_*`, go to SETUP.
- SETUP (`wrn`=1, 1 cycle) → STROBE.
- STROBE (`wrn`=0, `WR_LOW` cycles, counted by an internal counter) → RECOVER.
- RECOVER (`wrn`=1, 1 cycle) → IDLE.
- `ppu_sprite_*` change only on the IDLE→SETUP edge. They are stable from 1 cycle before `wrn` falls until 1 cycle after it rises.
- Throughput: 1 command per `WR_LOW`+3 cycles.

## Timing

- All outputs are registered; `ppu_wrn` comes straight from a flop, so it is glitch-free.
- Reset values (asynchronous, immediate): `ppu_wrn`=1; `ppu_sprite_x`/`y`/`id`=0; `cpu_rdata`=0; FIFO empty; overflow=0; stages and last_id 0; FSM IDLE.
- Latency, with the addr2 push sampled at edge E0 and the FSM idle:
  - E1: pop, outputs updated.
  - E2: `wrn` falls.
  - E(2+`WR_LOW`): `wrn` rises.
  - E(3+`WR_LOW`): FSM back in IDLE.
  - The next pop is at E(4+`WR_LOW`) at the earliest.
- Reset asserted mid-STROBE: `wrn` goes high immediately and the command is lost. After release, the FSM starts in IDLE with the FIFO empty.
- `cpu_wr` and `cpu_rd` asserted in the same cycle: both take effect. The read returns the pre-write value.

## Test plan

1. **Reset:** assert `ppu_rst`=0 with random inputs → `wrn`=1, sprite outputs 0, status read after release = 0x0001.
2. **Single command:** write X=320, Y=240, ID=5 (addr2 at E0) → `wrn` low exactly after E2 through E4 (`WR_LOW`=2); outputs 320/240/5 from E1 onward; status busy=1 until E5.
3. **Burst/overflow:** 12 consecutive addr2 pushes (IDs 0..11, `DEPTH`=8, `WR_LOW`=2) → exactly 10 `wrn` pulses with IDs 0..9 in order; IDs 10 and 11 dropped; status overflow=1, full observed after E9.
4. **Overflow clear:** after scenario 3, read addr3 twice → first read has [2]=1, second has [2]=0.
5. **Flush:** push 5 commands, then write addr3=1 while the first is in STROBE → that strobe completes; no further pulses; count=0, empty=1.
6. **Reset during STROBE:** drop `ppu_rst` while `wrn`=0 → `wrn`=1 in the same cycle. After release, a new push produces a normal pulse 2 cycles later.
